// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into
// word-indexed data_memory accesses, with read-modify-write and word splitting.
module load_store_unit #(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic [31:0] Read_addr,
    output logic [31:0] Write_Data,
    input  logic [31:0] Mem_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        LD0,
        LD1,
        ST_RD0,
        ST_WR0,
        ST_RD1,
        ST_WR1,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        unsigned_q;
    logic        err_q;

    logic        accept;
    logic [7:0]  req_lanes;
    logic        req_span;
    logic        req_bad;
    logic [7:0]  q_lanes;
    logic        q_span;
    logic [31:0] word0;
    logic [31:0] word1;
    logic [63:0] wdata_lanes;
    logic [31:0] merged_lo;
    logic [31:0] merged_hi;
    logic [31:0] load_window;
    logic [31:0] load_value;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    // Byte lanes touched across the two-word window {hi, lo}; any lane in the
    // upper half means the access spills into the next word.
    function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [1:0] size);
        lane_mask = {4'b0000, size_mask(size)} << off;
    endfunction

    assign accept    = req_valid && req_ready;
    assign req_lanes = lane_mask(req_addr[1:0], req_size);
    assign req_span  = |req_lanes[7:4];
    assign req_bad   = (req_size == 2'b11) || (req_span && !MISALIGN_EN);

    assign q_lanes = lane_mask(addr_q[1:0], size_q);
    assign q_span  = |q_lanes[7:4];

    assign word0 = {2'b00, addr_q[31:2]};
    assign word1 = {2'b00, addr_q[31:2] + 30'd1};

    assign wdata_lanes = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
    assign load_window = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            lo_q       <= 32'h0;
            hi_q       <= 32'h0;
            size_q     <= 2'b00;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                size_q     <= req_size;
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                err_q      <= req_bad;
            end
            if (state == LD0 || state == ST_RD0) begin
                lo_q <= Mem_data_out;
            end
            if (state == LD1 || state == ST_RD1) begin
                hi_q <= Mem_data_out;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        next_state = RESP;
                    end else if (!req_write) begin
                        next_state = LD0;
                    end else if (req_size == 2'b10 && req_addr[1:0] == 2'b00) begin
                        next_state = ST_WR0;
                    end else begin
                        next_state = ST_RD0;
                    end
                end
            end
            LD0:     next_state = q_span ? LD1 : RESP;
            LD1:     next_state = RESP;
            ST_RD0:  next_state = ST_WR0;
            ST_WR0:  next_state = q_span ? ST_RD1 : RESP;
            ST_RD1:  next_state = ST_WR1;
            ST_WR1:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Store data lands in the selected byte lanes; the rest keeps what was read.
    always_comb begin
        merged_lo = lo_q;
        merged_hi = hi_q;
        for (int i = 0; i < 4; i++) begin
            if (q_lanes[i]) begin
                merged_lo[8*i +: 8] = wdata_lanes[8*i +: 8];
            end
            if (q_lanes[i+4]) begin
                merged_hi[8*i +: 8] = wdata_lanes[32 + 8*i +: 8];
            end
        end
    end

    always_comb begin
        case (size_q)
            2'b00:   load_value = {{24{load_window[7] & ~unsigned_q}}, load_window[7:0]};
            2'b01:   load_value = {{16{load_window[15] & ~unsigned_q}}, load_window[15:0]};
            default: load_value = load_window;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        rsp_valid  = (state == RESP);
        rsp_err    = 1'b0;
        rsp_rdata  = 32'h0;
        Mem_Read   = 1'b0;
        Mem_Write  = 1'b0;
        Read_addr  = 32'h0;
        Write_Data = 32'h0;
        case (state)
            LD0, ST_RD0: begin
                Mem_Read  = 1'b1;
                Read_addr = word0;
            end
            LD1, ST_RD1: begin
                Mem_Read  = 1'b1;
                Read_addr = word1;
            end
            ST_WR0: begin
                Mem_Write  = 1'b1;
                Read_addr  = word0;
                Write_Data = merged_lo;
            end
            ST_WR1: begin
                Mem_Write  = 1'b1;
                Read_addr  = word1;
                Write_Data = merged_hi;
            end
            RESP: begin
                rsp_err = err_q;
                if (!write_q && !err_q) begin
                    rsp_rdata = load_value;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
